add_sub_sched: RTL
==================

ADD_SUB_SCHED -- requirements
Module: add_sub_sched

Interface
REQ-001 Parameter: CNT_W, 8, width of the completed-operation counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; all state changes on the rising clock edge.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0, req1  input  1 each  operation request from requester 0 / 1; level, held until grant.
REQ-006 a0, b0, a1, b1  input  4 each  unsigned operands of requester 0 / 1.
REQ-007 m0, m1  input  1 each  mode of requester 0 / 1: 0 = add, 1 = subtract.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant: operands of that requester captured.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 s  output  5  registered result magnitude.
REQ-011 sign  output  1  registered result sign: 1 = negative.
REQ-012 done  output  1  one-cycle pulse: s/sign/done_id valid.
REQ-013 done_id  output  1  requester that owns the current result.
REQ-014 op_cnt  output  CNT_W  count of completed operations.

Function
REQ-015 The block SHALL share one add/sub datapath between two requesters via FSM states IDLE, CALC, DONE.
REQ-016 IDLE, no req asserted: remain IDLE, all pulses low.
REQ-017 IDLE, at least one req at the edge: latch a, b, m of the winner; assert its gnt for exactly the following cycle; go CALC.
REQ-018 Arbitration SHALL be round-robin: on simultaneous req0 and req1, the requester not served last wins; a single requester always wins.
REQ-019 CALC: on the next edge, register s, sign and done_id; drop gnt; assert done; go DONE.
REQ-020 DONE: on the next edge, drop done; increment op_cnt; go IDLE. Requests are not sampled in CALC or DONE.
REQ-021 Latency: done is high in the 2nd cycle after the request-sampling edge; peak throughput is one operation per 3 cycles.
REQ-022 Add (m=0): s = a + b as a 5-bit value, carry in s[4]; sign = 0.
REQ-023 Subtract (m=1): a >= b gives s = a - b, sign = 0; a < b gives s = b - a, sign = 1; s[4] = 0.
REQ-024 s, sign and done_id SHALL hold their values until the next CALC-to-DONE transition.
REQ-025 op_cnt SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-026 A req deasserted before the grant SHALL be dropped; no grant and no operation result.
REQ-027 A req still high after its done pulse SHALL be treated as a new request in IDLE and arbitrated normally.
REQ-028 Operand changes after the grant SHALL NOT affect the result in flight.

Reset
REQ-029 On rst high, immediately and regardless of the clock: state = IDLE; gnt0 = gnt1 = busy = done = 0; s = 0; sign = 0; done_id = 0; op_cnt = 0; last-served = 1, so requester 0 wins the first tie.
REQ-030 Reset mid-operation (CALC or DONE) SHALL abort it: no done pulse, op_cnt not incremented.
REQ-031 The first request is sampled on the first rising edge after rst deasserts.

Verification
REQ-032 After reset, req0 only, a0=0, b0=15, m0=0 -> gnt0 one cycle, then done with s=15, sign=0, done_id=0, op_cnt=1.
REQ-033 req1 only, a1=0, b1=15, m1=1 -> s=15, sign=1, done_id=1.
REQ-034 req0 and req1 held together: req0 {12,11,add}, req1 {11,12,sub} -> first done s=23, sign=0, id=0; second done s=1, sign=1, id=1; grants alternate.
REQ-035 Subtract edge case a=15, b=0 -> s=15, sign=0; a=1, b=1 -> s=0, sign=0.
REQ-036 rst pulsed while in CALC -> outputs zero immediately, no done pulse, op_cnt unchanged at 0.
REQ-037 256 back-to-back operations with CNT_W=8 -> op_cnt reads 0, and every done pulse is spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/add_sub_sched.sv
// -----------------------------------------------------------------------------
// add_sub_sched
//   Shares one 4-bit add/subtract datapath between two requesters. A small
//   three-state FSM (IDLE -> CALC -> DONE) takes one operation at a time.
//   Simultaneous requests are arbitrated round-robin. Results are presented
//   as a sign/magnitude pair.
//
// Ports
//   clk            system clock (all state changes on the rising edge)
//   rst            asynchronous active-high reset
//   req0 / req1    level request, held by the requester until its grant
//   a0,b0 / a1,b1  4-bit unsigned operands of requester 0 / 1
//   m0 / m1        mode of requester 0 / 1: 0 = add, 1 = subtract
//   gnt0 / gnt1    one-cycle grant: this requester's operands were captured
//   busy           high whenever the FSM is not IDLE
//   s              registered result magnitude (carry in s[4] for add)
//   sign           registered result sign, 1 = negative
//   done           one-cycle pulse: s / sign / done_id are valid
//   done_id        requester that owns the current result
//   op_cnt         count of completed operations (wraps silently)
// -----------------------------------------------------------------------------
module add_sub_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  input  logic             m0,
  input  logic             m1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [4:0]       s,
  output logic             sign,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {sign, magnitude[4:0]}. Subtraction always yields the
  // non-negative difference, with the sign carrying the direction.
  function automatic logic [5:0] add_sub_calc(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       m
  );
    logic [5:0] r;
    if (!m) begin
      r = {1'b0, ({1'b0, a} + {1'b0, b})};
    end else if (a >= b) begin
      r = {1'b0, 1'b0, (a - b)};
    end else begin
      r = {1'b1, 1'b0, (b - a)};
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic             m_q, m_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       s_q, s_d;
  logic             sign_q, sign_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             win_s;
  logic [5:0]       res_s;

  // Next-state, operand capture, result and counter logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    id_d      = id_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    s_d       = s_q;
    sign_d    = sign_q;
    done_id_d = done_id_q;
    op_cnt_d  = op_cnt_q;
    win_s     = 1'b0;
    res_s     = add_sub_calc(a_q, b_q, m_q);

    case (state_q)
      ST_IDLE: begin
        // On a tie the requester that was not served last wins.
        if (req0 && req1) begin
          win_s = ~last_q;
        end else if (req1) begin
          win_s = 1'b1;
        end else begin
          win_s = 1'b0;
        end

        if (req0 || req1) begin
          state_d = ST_CALC;
          id_d    = win_s;
          last_d  = win_s;
          gnt0_d  = ~win_s;
          gnt1_d  = win_s;
          if (win_s) begin
            a_d = a1;
            b_d = b1;
            m_d = m1;
          end else begin
            a_d = a0;
            b_d = b0;
            m_d = m0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        s_d       = res_s[4:0];
        sign_d    = res_s[5];
        done_id_d = id_q;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        op_cnt_d = op_cnt_q + CNT_ONE;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered from the next state so it tracks the state register.
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      m_q       <= 1'b0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_q       <= 5'd0;
      sign_q    <= 1'b0;
      done_id_q <= 1'b0;
      op_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      id_q      <= id_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_q       <= s_d;
      sign_q    <= sign_d;
      done_id_q <= done_id_d;
      op_cnt_q  <= op_cnt_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign s       = s_q;
  assign sign    = sign_q;
  assign done_id = done_id_q;
  assign op_cnt  = op_cnt_q;

endmodule
